// File: rtl/sine_voice_scheduler.sv
// Shares one synchronous quarter-wave sine ROM among NUM_VOICES phase-accumulator voices and mixes them per frame.
// Optional build macro MIX_SATURATE_EN: mix is the clamped full-precision sum instead of the averaged (>>> VW) sum.
module sine_voice_scheduler #(
    parameter int unsigned NUM_VOICES = 4,
    localparam int unsigned VW = $clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_frame,
    input  logic [NUM_VOICES-1:0] voice_en,
    input  logic                  cfg_we,
    input  logic [VW-1:0]         cfg_voice,
    input  logic [19:0]           cfg_step,
    output logic [9:0]            rom_addr,
    input  logic [15:0]           rom_dout,
    output logic [15:0]           mix_sample,
    output logic                  mix_ready,
    output logic                  frame_overrun
);

    localparam int unsigned PW   = 22;
    localparam int unsigned SW   = 20;
    localparam int unsigned DW   = 16;
    localparam int unsigned ACCW = DW + VW;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] ACCUM = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  accept;
    logic                  last_voice;
    logic [VW-1:0]         idx;
    logic [NUM_VOICES-1:0] en_lat;
    logic [PW-1:0]         phase [NUM_VOICES];
    logic [SW-1:0]         step  [NUM_VOICES];
    logic [SW-1:0]         snap  [NUM_VOICES];
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] addend;
    logic signed [ACCW-1:0] acc_sum;
    logic [PW-1:0]         cur_phase;
    logic [9:0]            fold_addr;
    logic [DW-1:0]         sample;
    logic [DW-1:0]         mix_val;

    // Next-state logic; new_frame is only honoured in IDLE and OUT
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (new_frame) begin
                    accept     = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: state_next = ACCUM;
            ACCUM: state_next = last_voice ? OUT : FETCH;
            OUT: begin
                if (new_frame) begin
                    accept     = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Quadrant fold, sign, and running sum for the voice under service
    always_comb begin
        last_voice = (idx == VW'(NUM_VOICES - 1));
        cur_phase  = phase[idx];
        fold_addr  = cur_phase[20] ? (10'd1023 - cur_phase[19:10]) : cur_phase[19:10];
        rom_addr   = (state == FETCH) ? fold_addr : 10'd0;
        sample     = cur_phase[21] ? DW'(16'd0 - rom_dout) : rom_dout;
        addend     = en_lat[idx] ? {{VW{sample[DW-1]}}, sample} : '0;
        acc_sum    = acc + addend;
`ifdef MIX_SATURATE_EN
        if (acc_sum > ACCW'(32767)) begin
            mix_val = 16'h7FFF;
        end else if (acc_sum < ACCW'(-32768)) begin
            mix_val = 16'h8000;
        end else begin
            mix_val = DW'(acc_sum);
        end
`else
        mix_val = DW'(acc_sum >>> VW);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Per-voice state, frame sequencing and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            idx           <= '0;
            en_lat        <= '0;
            acc           <= '0;
            mix_sample    <= '0;
            mix_ready     <= 1'b0;
            frame_overrun <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase[v] <= '0;
                step[v]  <= '0;
                snap[v]  <= '0;
            end
        end else begin
            mix_ready <= 1'b0;
            if (cfg_we) begin
                step[cfg_voice] <= cfg_step;
            end
            if (new_frame && ((state == FETCH) || (state == ACCUM))) begin
                frame_overrun <= 1'b1;
            end
            if (accept) begin
                acc    <= '0;
                idx    <= '0;
                en_lat <= voice_en;
                // A step written in the accept cycle already counts for this frame
                for (int v = 0; v < NUM_VOICES; v++) begin
                    snap[v] <= (cfg_we && (cfg_voice == VW'(v))) ? cfg_step : step[v];
                end
            end
            if (state == ACCUM) begin
                acc <= acc_sum;
                if (en_lat[idx]) begin
                    phase[idx] <= cur_phase + {2'b00, snap[idx]};
                end
                if (last_voice) begin
                    mix_sample <= mix_val;
                    mix_ready  <= 1'b1;
                end else begin
                    idx <= idx + VW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Scoreboard bench for sine_voice_scheduler: frames push expected mixes, a negedge monitor pops on mix_ready.
module tb_sine_voice_scheduler;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         new_frame;
    logic [N-1:0] voice_en;
    logic         cfg_we;
    logic [1:0]   cfg_voice;
    logic [19:0]  cfg_step;
    logic [9:0]   rom_addr;
    logic [15:0]  rom_dout;
    logic [15:0]  mix_sample;
    logic         mix_ready;
    logic         frame_overrun;

    typedef struct {
        logic [15:0] mix;
        int          at;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   ready_cnt = 0;
    int   r0;

    sine_voice_scheduler #(.NUM_VOICES(N)) dut (
        .clk(clk),
        .reset(reset),
        .new_frame(new_frame),
        .voice_en(voice_en),
        .cfg_we(cfg_we),
        .cfg_voice(cfg_voice),
        .cfg_step(cfg_step),
        .rom_addr(rom_addr),
        .rom_dout(rom_dout),
        .mix_sample(mix_sample),
        .mix_ready(mix_ready),
        .frame_overrun(frame_overrun)
    );

    always #5 clk = ~clk;

    // Synchronous ROM model: dout = addr << 5
    always @(posedge clk) rom_dout <= 16'({rom_addr, 5'b00000});

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mix_ready === 1'b1) begin
            ready_cnt++;
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ready: mix_ready at cycle %0d with nothing outstanding", cyc);
            end else begin
                mon_e = q.pop_front();
                check("mix_sample", 32'(mix_sample), 32'(mon_e.mix));
                check("ready_cycle", cyc, mon_e.at);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] v, input logic [19:0] s);
        cfg_we    = 1'b1;
        cfg_voice = v;
        cfg_step  = s;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic frame(input logic [9:0] exp_addr, input logic [15:0] exp_mix);
        new_frame = 1'b1;
        q.push_back('{exp_mix, cyc + 9});
        tick();
        new_frame = 1'b0;
        check("fetch_addr_v0", 32'(rom_addr), 32'(exp_addr));
        repeat (9) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        new_frame = 1'b0;
        voice_en  = '0;
        cfg_we    = 1'b0;
        cfg_voice = '0;
        cfg_step  = '0;
        tick();
        do_reset();

        check("rst_mix_sample", 32'(mix_sample), 32'd0);
        check("rst_mix_ready", 32'(mix_ready), 32'd0);
        check("rst_overrun", 32'(frame_overrun), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        r0 = ready_cnt;
        repeat (20) tick();
        check("idle_no_ready", ready_cnt, r0);

        // Single voice walking up the table
        voice_en = 4'b0001;
        cfg(2'd0, 20'h00400);
        frame(10'd0, 16'd0);
        frame(10'd1, 16'd8);
        frame(10'd2, 16'd16);

        // Quadrant fold and sign
        do_reset();
        voice_en = 4'b0001;
        cfg(2'd0, 20'hFFC00);
        frame(10'd0, 16'd0);
        frame(10'd1023, 16'd8184);
        frame(10'd1, 16'd8);
        frame(10'd1021, 16'hE018);

        // Full mix, then partial enables into a negative sum
        do_reset();
        voice_en = 4'b1111;
        for (int v = 0; v < 4; v++) cfg(2'(v), 20'hFFC00);
        frame(10'd0, 16'd0);
`ifdef MIX_SATURATE_EN
        frame(10'd1023, 16'd32767);
        voice_en = 4'b0101;
        frame(10'd1, 16'd64);
        voice_en = 4'b1111;
        frame(10'd1021, 16'h8000);
`else
        frame(10'd1023, 16'd32736);
        voice_en = 4'b0101;
        frame(10'd1, 16'd16);
        voice_en = 4'b1111;
        frame(10'd1021, 16'hC040);
`endif

        // Overrun and step write during a frame
        do_reset();
        voice_en = 4'b0001;
        cfg(2'd0, 20'h00400);
        new_frame = 1'b1;
        q.push_back('{16'd0, cyc + 9});
        tick();
        new_frame = 1'b0;
        check("ovr_fetch_addr", 32'(rom_addr), 32'd0);
        check("ovr_before", 32'(frame_overrun), 32'd0);
        repeat (2) tick();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        check("ovr_set", 32'(frame_overrun), 32'd1);
        cfg(2'd0, 20'h00800);
        repeat (9) tick();
        frame(10'd1, 16'd8);
        frame(10'd3, 16'd24);
        check("ovr_sticky", 32'(frame_overrun), 32'd1);

        // Reset in the middle of a frame
        r0 = ready_cnt;
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (6) tick();
        check("abort_no_ready", ready_cnt, r0);
        check("abort_overrun_clr", 32'(frame_overrun), 32'd0);
        voice_en = 4'b0001;
        cfg(2'd0, 20'h00400);
        frame(10'd0, 16'd0);

        repeat (3) tick();
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
